// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared constants and types for the RV32I fetch/prefetch stage.
// FSM encodings, reset defaults and the prefetch queue entry layout.
package fetch_prefetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

  function automatic logic [31:0] align4(
    input logic [31:0] a
  );
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular prefetch FIFO of {pc, instr} entries.
// Supports simultaneous push/pop and a single-cycle flush.
module fetch_queue
  import fetch_prefetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      push_i,
  input  logic      pop_i,
  input  logic      flush_i,
  input  fq_entry_t wdata_i,
  output fq_entry_t rdata_o,
  output logic [AW:0] count_o,
  output logic      empty_o
);

  fq_entry_t       mem_q [DEPTH];
  logic [AW-1:0]   wr_q, wr_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [AW:0]     cnt_q, cnt_d;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + 1'b1;
      if (pop_i)  rd_d = rd_q + 1'b1;
      if (push_i && !pop_i) cnt_d = cnt_q + 1'b1;
      if (pop_i && !push_i) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/fetch_prefetch_unit.sv
// IF stage: PC generation, single-outstanding I-cache reads,
// prefetch queue and the IF/ID pipeline register.
module fetch_prefetch_unit
  import fetch_prefetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter int          QDEPTH    = 2,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] iaddr,
  output logic        iread,
  input  logic [31:0] idata,
  input  logic        iready_n,
  input  logic        stall_ID,
  input  logic        nop_IF,
  input  logic        branch_PC_contral,
  input  logic [31:0] branch_PC,
  input  logic        branch_PC_early_contral,
  input  logic [31:0] branch_PC_early,
  output logic [31:0] Instraction_pype,
  output logic [31:0] PC_pype,
  output logic        if_valid_pype
);

  localparam int QAW = $clog2(QDEPTH);
  localparam logic [QAW:0] QFULL = (QAW+1)'(QDEPTH);

  logic [1:0]  state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;

  logic        redirect;
  logic [31:0] target;
  logic        resp;
  logic        issue;
  logic        push;
  logic        pop;

  fq_entry_t   q_head;
  fq_entry_t   q_wdata;
  logic [QAW:0] q_count;
  logic        q_empty;

  assign redirect = branch_PC_contral
                  | branch_PC_early_contral;
  assign target = align4(branch_PC_contral
                         ? branch_PC
                         : branch_PC_early);
  assign resp = !iready_n;

  // Gated by rst so the request line is low while reset is held.
  assign issue = rst
               && (state_q == S_IDLE)
               && !redirect
               && (q_count != QFULL);

  assign push = (state_q == S_WAIT)
              && resp && !redirect;
  assign pop  = !redirect && !stall_ID
              && !nop_IF && !q_empty;

  assign q_wdata = '{pc: fetch_pc_q, instr: idata};

  assign iread = issue;
  assign iaddr = fetch_pc_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    unique case (state_q)
      S_IDLE: begin
        if (issue) state_d = S_WAIT;
      end
      S_WAIT: begin
        // A redirect coinciding with the response drops that word.
        if (resp) begin
          state_d = S_IDLE;
          if (!redirect) fetch_pc_d = fetch_pc_q + 32'd4;
        end else if (redirect) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (resp) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (redirect) fetch_pc_d = target;
  end

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (redirect
        || (!stall_ID && (nop_IF || q_empty))) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (pop) begin
      instr_d = q_head.instr;
      pc_d    = q_head.pc;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      instr_q    <= NOP_INSTR;
      pc_q       <= 32'h0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
    end
  end

  fetch_queue #(
    .DEPTH(QDEPTH)
  ) u_queue (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect),
    .wdata_i (q_wdata),
    .rdata_o (q_head),
    .count_o (q_count),
    .empty_o (q_empty)
  );

  assign Instraction_pype = instr_q;
  assign PC_pype          = pc_q;
  assign if_valid_pype    = valid_q;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Self-checking bench for fetch_prefetch_unit: directed table,
// hand-written corner sequences and a randomized scoreboard run.
module tb_fetch_prefetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] iaddr;
  logic        iread;
  logic [31:0] idata;
  logic        iready_n;
  logic        stall_ID;
  logic        nop_IF;
  logic        branch_PC_contral;
  logic [31:0] branch_PC;
  logic        branch_PC_early_contral;
  logic [31:0] branch_PC_early;
  logic [31:0] Instraction_pype;
  logic [31:0] PC_pype;
  logic        if_valid_pype;

  fetch_prefetch_unit dut (
    .clk                     (clk),
    .rst                     (rst),
    .iaddr                   (iaddr),
    .iread                   (iread),
    .idata                   (idata),
    .iready_n                (iready_n),
    .stall_ID                (stall_ID),
    .nop_IF                  (nop_IF),
    .branch_PC_contral       (branch_PC_contral),
    .branch_PC               (branch_PC),
    .branch_PC_early_contral (branch_PC_early_contral),
    .branch_PC_early         (branch_PC_early),
    .Instraction_pype        (Instraction_pype),
    .PC_pype                 (PC_pype),
    .if_valid_pype           (if_valid_pype)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        nop;
    logic        brx;
    logic [31:0] brx_pc;
    logic        bre;
    logic [31:0] bre_pc;
  } ctl_t;

  typedef struct {
    logic        stall;
    logic        exp_iread;
    logic [31:0] exp_iaddr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // I-cache model: one pending request, response after lat cycles
  bit          pend = 0;
  logic [31:0] paddr = '0;
  int          pwait = 0;
  int          lat = 1;
  bit          spurious_en = 0;

  logic        s_iread;
  logic [31:0] s_iaddr;

  function automatic logic [31:0] wordof(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic ctl_t idle_ctl();
    ctl_t c;
    c.stall = 1'b0; c.nop = 1'b0;
    c.brx = 1'b0; c.brx_pc = '0;
    c.bre = 1'b0; c.bre_pc = '0;
    return c;
  endfunction

  function automatic logic [31:0] tgt();
    if ($urandom_range(3) == 0)
      return 32'hFFFF_FFF0 | 32'($urandom_range(15));
    return $urandom;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input ctl_t c);
    bit pend_before;
    if (pend && pwait == 0) begin
      iready_n = 1'b0;
      idata = wordof(paddr);
      pend = 0;
    end else begin
      if (pend) pwait--;
      iready_n = (!pend && spurious_en
                  && $urandom_range(9) == 0) ? 1'b0 : 1'b1;
      idata = $urandom;
    end
    pend_before = pend;
    stall_ID = c.stall;
    nop_IF = c.nop;
    branch_PC_contral = c.brx;
    branch_PC = c.brx_pc;
    branch_PC_early_contral = c.bre;
    branch_PC_early = c.bre_pc;
    #1;
    s_iread = iread;
    s_iaddr = iaddr;
    if (iread) begin
      chk("single_outstanding", 64'(pend_before), 64'(0));
      pend = 1;
      paddr = iaddr;
      pwait = lat - 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    pend = 0;
    cyc_inputs_idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic cyc_inputs_idle();
    iready_n = 1'b1;
    idata = '0;
    stall_ID = 1'b0;
    nop_IF = 1'b0;
    branch_PC_contral = 1'b0;
    branch_PC = '0;
    branch_PC_early_contral = 1'b0;
    branch_PC_early = '0;
  endtask

  task automatic wait_first(input string nm,
                            input logic [31:0] pc);
    bit found = 0;
    ctl_t c0 = idle_ctl();
    for (int i = 0; i < 30 && !found; i++) begin
      cyc(c0);
      if (if_valid_pype) begin
        found = 1;
        chk({nm, "_pc"}, 64'(PC_pype), 64'(pc));
        chk({nm, "_instr"}, 64'(Instraction_pype),
            64'(wordof(pc)));
      end
    end
    chk({nm, "_timeout"}, 64'(found), 64'(1));
  endtask

  vec_t tbl [22];

  initial begin
    ctl_t c;
    ctl_t c0;
    logic [31:0] exp_pc;
    logic [31:0] p_instr, p_pc;
    logic        p_valid;
    int          deliveries;
    c0 = idle_ctl();

    // no-stall stream, then a long stall with the queue full
    tbl[0]  = '{1'b0, 1'b1, 32'd0,  1'b0, 32'd0};
    tbl[1]  = '{1'b0, 1'b0, 32'd0,  1'b0, 32'd0};
    tbl[2]  = '{1'b0, 1'b1, 32'd4,  1'b1, 32'd0};
    tbl[3]  = '{1'b0, 1'b0, 32'd0,  1'b0, 32'd0};
    tbl[4]  = '{1'b0, 1'b1, 32'd8,  1'b1, 32'd4};
    tbl[5]  = '{1'b0, 1'b0, 32'd0,  1'b0, 32'd0};
    tbl[6]  = '{1'b0, 1'b1, 32'd12, 1'b1, 32'd8};
    tbl[7]  = '{1'b0, 1'b0, 32'd0,  1'b0, 32'd0};
    tbl[8]  = '{1'b0, 1'b1, 32'd16, 1'b1, 32'd12};
    tbl[9]  = '{1'b0, 1'b0, 32'd0,  1'b0, 32'd0};
    tbl[10] = '{1'b0, 1'b1, 32'd20, 1'b1, 32'd16};
    tbl[11] = '{1'b1, 1'b0, 32'd0,  1'b1, 32'd16};
    tbl[12] = '{1'b1, 1'b1, 32'd24, 1'b1, 32'd16};
    tbl[13] = '{1'b1, 1'b0, 32'd0,  1'b1, 32'd16};
    tbl[14] = '{1'b1, 1'b0, 32'd0,  1'b1, 32'd16};
    tbl[15] = '{1'b1, 1'b0, 32'd0,  1'b1, 32'd16};
    tbl[16] = '{1'b1, 1'b0, 32'd0,  1'b1, 32'd16};
    tbl[17] = '{1'b0, 1'b0, 32'd0,  1'b1, 32'd20};
    tbl[18] = '{1'b0, 1'b1, 32'd28, 1'b1, 32'd24};
    tbl[19] = '{1'b0, 1'b0, 32'd0,  1'b0, 32'd0};
    tbl[20] = '{1'b0, 1'b1, 32'd32, 1'b1, 32'd28};
    tbl[21] = '{1'b0, 1'b0, 32'd0,  1'b0, 32'd0};

    cyc_inputs_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_instr", 64'(Instraction_pype), 64'(NOP));
    chk("rst_pc", 64'(PC_pype), 64'(0));
    chk("rst_valid", 64'(if_valid_pype), 64'(0));
    chk("rst_iread", 64'(iread), 64'(0));
    chk("rst_iaddr", 64'(iaddr), 64'(0));
    rst = 1'b1;

    lat = 1;
    for (int r = 0; r < 22; r++) begin
      c = c0;
      c.stall = tbl[r].stall;
      cyc(c);
      chk($sformatf("tbl%0d_iread", r),
          64'(s_iread), 64'(tbl[r].exp_iread));
      if (tbl[r].exp_iread)
        chk($sformatf("tbl%0d_iaddr", r),
            64'(s_iaddr), 64'(tbl[r].exp_iaddr));
      chk($sformatf("tbl%0d_valid", r),
          64'(if_valid_pype), 64'(tbl[r].exp_valid));
      if (tbl[r].exp_valid) begin
        chk($sformatf("tbl%0d_pc", r),
            64'(PC_pype), 64'(tbl[r].exp_pc));
        chk($sformatf("tbl%0d_instr", r),
            64'(Instraction_pype), 64'(wordof(tbl[r].exp_pc)));
      end else begin
        chk($sformatf("tbl%0d_nop", r),
            64'(Instraction_pype), 64'(NOP));
      end
    end

    // EX redirect while a request is outstanding
    do_reset();
    lat = 1;
    for (int i = 0; i < 4; i++) cyc(c0);
    lat = 3;
    cyc(c0);
    chk("t3_pre_pc", 64'(PC_pype), 64'(4));
    c = c0;
    c.brx = 1'b1;
    c.brx_pc = 32'h103;
    cyc(c);
    chk("t3_iread_redir", 64'(s_iread), 64'(0));
    chk("t3_bubble", 64'(Instraction_pype), 64'(NOP));
    chk("t3_bubble_valid", 64'(if_valid_pype), 64'(0));
    begin
      bit got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
        cyc(c0);
        if (s_iread) begin
          got = 1;
          chk("t3_req_addr", 64'(s_iaddr), 64'(32'h100));
        end
      end
      chk("t3_req_timeout", 64'(got), 64'(1));
    end
    wait_first("t3_first", 32'h100);

    // both redirects: EX wins
    c = c0;
    c.brx = 1'b1; c.brx_pc = 32'h200;
    c.bre = 1'b1; c.bre_pc = 32'h300;
    cyc(c);
    chk("t4_iread_redir", 64'(s_iread), 64'(0));
    chk("t4_bubble_valid", 64'(if_valid_pype), 64'(0));
    wait_first("t4_first", 32'h200);

    // nop_IF bubble with PC 8 waiting in the queue
    do_reset();
    lat = 1;
    for (int i = 0; i < 6; i++) cyc(c0);
    c = c0;
    c.nop = 1'b1;
    cyc(c);
    chk("t5_nop_valid", 64'(if_valid_pype), 64'(0));
    chk("t5_nop_instr", 64'(Instraction_pype), 64'(NOP));
    cyc(c0);
    chk("t5_next_valid", 64'(if_valid_pype), 64'(1));
    chk("t5_next_pc", 64'(PC_pype), 64'(8));
    chk("t5_next_instr", 64'(Instraction_pype), 64'(wordof(8)));
    cyc(c0);
    chk("t5_after_pc", 64'(PC_pype), 64'(12));

    // asynchronous reset during an outstanding request
    do_reset();
    lat = 1;
    for (int i = 0; i < 4; i++) cyc(c0);
    lat = 3;
    cyc(c0);
    #3;
    rst = 1'b0;
    #1;
    chk("t6_iread", 64'(iread), 64'(0));
    chk("t6_iaddr", 64'(iaddr), 64'(0));
    chk("t6_valid", 64'(if_valid_pype), 64'(0));
    chk("t6_instr", 64'(Instraction_pype), 64'(NOP));
    chk("t6_pc", 64'(PC_pype), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    pwait = 0;
    lat = 1;
    cyc(c0);
    chk("t6_restart_iread", 64'(s_iread), 64'(1));
    chk("t6_restart_iaddr", 64'(s_iaddr), 64'(0));
    wait_first("t6_first", 32'h0);

    // randomized run against an in-order stream scoreboard
    do_reset();
    spurious_en = 1;
    exp_pc = 32'h0;
    deliveries = 0;
    for (int n = 0; n < 3000; n++) begin
      c = c0;
      c.stall = ($urandom_range(4) == 0);
      c.nop = ($urandom_range(9) == 0);
      c.brx = ($urandom_range(24) == 0);
      c.bre = ($urandom_range(24) == 0);
      c.brx_pc = tgt();
      c.bre_pc = tgt();
      lat = $urandom_range(1, 4);
      p_instr = Instraction_pype;
      p_pc = PC_pype;
      p_valid = if_valid_pype;
      cyc(c);
      if (c.brx || c.bre) begin
        chk("rnd_iread_redir", 64'(s_iread), 64'(0));
        chk("rnd_redir_valid", 64'(if_valid_pype), 64'(0));
        chk("rnd_redir_instr", 64'(Instraction_pype), 64'(NOP));
        exp_pc = (c.brx ? c.brx_pc : c.bre_pc) & 32'hFFFF_FFFC;
      end else if (c.stall) begin
        chk("rnd_hold_valid", 64'(if_valid_pype), 64'(p_valid));
        chk("rnd_hold_pc", 64'(PC_pype), 64'(p_pc));
        chk("rnd_hold_instr", 64'(Instraction_pype), 64'(p_instr));
      end else if (c.nop) begin
        chk("rnd_nop_valid", 64'(if_valid_pype), 64'(0));
        chk("rnd_nop_instr", 64'(Instraction_pype), 64'(NOP));
      end else if (if_valid_pype) begin
        chk("rnd_pc", 64'(PC_pype), 64'(exp_pc));
        chk("rnd_instr", 64'(Instraction_pype),
            64'(wordof(exp_pc)));
        exp_pc = exp_pc + 32'd4;
        deliveries++;
      end else begin
        chk("rnd_empty_nop", 64'(Instraction_pype), 64'(NOP));
      end
      if (s_iread)
        chk("rnd_iaddr_align", 64'(s_iaddr[1:0]), 64'(0));
    end
    chk("rnd_progress", 64'(deliveries > 100), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
